uart_tx: RTL and testbench

//  UART transmitter feeding the uart_rx receiver; runs on the same 3125 kHz clock.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_bit_timer.sv | 26 ++
 rtl/uart_tx.sv | 143 ++++++++++++++
 tb/tb_uart_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and line levels.
// Used by uart_tx and uart_rx so both ends agree on framing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } uart_state_t;

    localparam int   CLKS_PER_BIT = 14;
    localparam int   DATA_BITS    = 8;
    localparam logic IDLE_LVL     = 1'b1;
    localparam logic START_LVL    = 1'b0;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter 0..CLKS_PER_BIT-1; bit_end marks the last clock of a bit.
// clr holds the count at zero (used while idle and when the inter-frame gap ends).
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic          clk_3125,
    input  logic          rst,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          bit_end
);

    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits MSB-first, optional even parity (UART_TX_PARITY_EN), stop, idle gap.
// tx is registered, so the line follows the FSM state by one clock.
module uart_tx #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int IDLE_GAP     = 1
) (
    input  logic       clk_3125,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    import uart_pkg::*;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_t          state;
    uart_state_t          state_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           bit_idx;
    logic [CW-1:0]        cnt;
    logic                 bit_end;
    logic                 gap_end;
    logic                 timer_clr;
    logic                 accept;
    logic                 finish;
    logic                 tx_lvl;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    // GAP reuses the bit counter but ends after IDLE_GAP clocks instead of a full bit
    assign gap_end   = (state == GAP) && (cnt == CW'(IDLE_GAP - 1));
    assign timer_clr = (state == IDLE) || gap_end;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_3125 (clk_3125),
        .rst      (rst),
        .clr      (timer_clr),
        .cnt      (cnt),
        .bit_end  (bit_end)
    );

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_lvl    = IDLE_LVL;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_lvl = START_LVL;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                tx_lvl = shreg[DATA_BITS-1];
                if (bit_end && (bit_idx == 3'd0)) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_lvl = parity_q;
                if (bit_end) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (IDLE_GAP == 0) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_end) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            tx      <= IDLE_LVL;
            busy    <= 1'b0;
            tx_done <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            tx      <= tx_lvl;
            tx_done <= finish;
            if (accept) begin
                busy    <= 1'b1;
                shreg   <= tx_data;
                bit_idx <= 3'(DATA_BITS - 1);
            end else begin
                if (finish) busy <= 1'b0;
                if ((state == DATA) && bit_end) begin
                    shreg   <= shreg << 1;
                    bit_idx <= bit_idx - 1'b1;
                end
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= even_parity(tx_data);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus random bytes against a line-level model.
module tb_uart_tx;

    localparam int CPB = 14;
    localparam int GAP = 1;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int L = NB * CPB + GAP;

    logic       clk_3125 = 1'b0;
    logic       rst      = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .IDLE_GAP     (GAP)
    ) dut (
        .clk_3125 (clk_3125),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #5 clk_3125 = ~clk_3125;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level k clocks after the accepting edge: frame bits, each CPB clocks, then high.
    function automatic logic exp_line(input logic [7:0] d, input int k);
        int b;
        if (k < 1 || k > NB * CPB) return 1'b1;
        b = (k - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[8 - b];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Sends one byte; keep holds tx_start high (back-to-back), poke pulses a 8'h55 request
    // mid-frame, rst_at asserts reset at that clock of the frame.
    task automatic frame(input logic [7:0] d, input bit keep, input int poke,
                         input int rst_at, input string tag);
        int         err;
        int         first_bad;
        int         done_at;
        int         i;
        int         quiet_bad;
        logic [7:0] dec;
        logic       dec_start;
        logic       dec_stop;
        logic       dec_par;
        bit         aborted;
        err = 0; first_bad = -1; done_at = -1; quiet_bad = 0;
        dec = 8'h00; dec_start = 1'b1; dec_stop = 1'b0; dec_par = 1'b0; aborted = 1'b0;
        @(negedge clk_3125);
        tx_start = 1'b1;
        tx_data  = d;
        @(posedge clk_3125);
        for (int k = 1; k <= L && !aborted; k++) begin
            @(negedge clk_3125);
            if (keep) tx_data = 8'($urandom);
            else      tx_start = 1'b0;
            if (k == poke) begin
                tx_start = 1'b1;
                tx_data  = 8'h55;
            end
            if (k == poke + 1) tx_start = 1'b0;
            @(posedge clk_3125);
            #1;
            if (tx !== exp_line(d, k) || busy !== (k < L) || tx_done !== (k == L)) begin
                err++;
                if (first_bad < 0) first_bad = k;
            end
            if (tx_done === 1'b1 && done_at < 0) done_at = k;
            if (k % CPB == CPB / 2) begin
                i = k / CPB;
                if (i == 0)            dec_start = tx;
                else if (i <= 8)       dec = {dec[6:0], tx};
                else if (i == NB - 1)  dec_stop = tx;
                else if (i == 9)       dec_par = tx;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check({tag, "_rst_tx"}, 32'(tx), 32'd1);
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_done"}, 32'(tx_done), 32'd0);
                @(negedge clk_3125);
                rst      = 1'b0;
                tx_start = 1'b0;
                aborted  = 1'b1;
            end
        end
        if (aborted) begin
            repeat (2 * L) begin
                @(posedge clk_3125);
                #1;
                if (tx_done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) quiet_bad++;
            end
            check({tag, "_quiet_after_rst"}, 32'(quiet_bad), 32'd0);
        end else begin
            check({tag, "_wave_errs"}, 32'(err), 32'd0);
            if (err != 0) $display("  %s first deviating clock %0d", tag, first_bad);
            check({tag, "_done_clk"}, 32'(done_at), 32'(L));
            check({tag, "_byte"}, 32'(dec), 32'(d));
            check({tag, "_start"}, 32'(dec_start), 32'd0);
            check({tag, "_stop"}, 32'(dec_stop), 32'd1);
`ifdef UART_TX_PARITY_EN
            check({tag, "_parity"}, 32'(dec_par), 32'(^d));
`endif
        end
    endtask

    initial begin
        logic [7:0] rb;
        rst = 1'b1;
        repeat (3) @(posedge clk_3125);
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(tx_done), 32'd0);
        @(negedge clk_3125);
        rst = 1'b0;
        repeat (3) @(posedge clk_3125);
        #1;
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        frame(8'h41, 1'b0, -1, -1, "t1_41");
        frame(8'h3F, 1'b0, -1, -1, "t2_3f");
        frame(8'h07, 1'b0, -1, -1, "t3_07");

        tx_start = 1'b1;
        frame(8'h01, 1'b1, -1, -1, "t4_01");
        frame(8'h80, 1'b1, -1, -1, "t4_80");
        frame(8'hFF, 1'b0, -1, -1, "t4_ff");

        frame(8'hAA, 1'b0, 40, -1, "t5_aa");
        repeat (6) @(posedge clk_3125);
        #1;
        check("t5_no_queue_busy", 32'(busy), 32'd0);
        check("t5_no_queue_tx", 32'(tx), 32'd1);

        frame(8'($urandom), 1'b0, -1, 60, "t6_abort");
        frame(8'hC3, 1'b0, -1, -1, "t6_clean");

        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk_3125);
            rb = 8'($urandom);
            frame(rb, 1'b0, -1, -1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
